// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//
// Shares one UART TX FIFO write port between a keyboard byte stream and a
// mouse report stream. The keyboard source is a first-word-fall-through FIFO
// that is popped with rd_kb. Mouse reports arrive as single-cycle ticks and
// are parked in a one-entry holding register until they are granted. Once
// granted, a mouse packet is sent without interruption.
//
// Build option:
//   UART_ARB_HEX_MS_EN  defined   -> each mouse byte is sent as two uppercase
//                                    ASCII hex characters, followed by CR LF
//                                    (8 bytes per packet)
//                       undefined -> the 3 raw mouse bytes are sent
//                                    (3 bytes per packet)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   kb_buf_empty  in   keyboard FIFO empty flag
//   kb_data[7:0]  in   keyboard FIFO head byte (valid while not empty)
//   rd_kb         out  one-cycle pop strobe to the keyboard FIFO (registered)
//   ms_valid      in   one-cycle mouse report tick
//   ms_pkt[23:0]  in   mouse report, byte0 = [7:0], byte2 = [23:16]
//   tx_full       in   UART TX FIFO full flag
//   wr_uart       out  one-cycle write strobe to the UART TX FIFO (registered)
//   w_data[7:0]   out  byte written with wr_uart (registered, 0 when idle)
//   ms_ovf        out  sticky flag, set when a mouse report was dropped
// ---------------------------------------------------------------------------
module uart_tx_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        kb_buf_empty,
    input  logic [7:0]  kb_data,
    output logic        rd_kb,
    input  logic        ms_valid,
    input  logic [23:0] ms_pkt,
    input  logic        tx_full,
    output logic        wr_uart,
    output logic [7:0]  w_data,
    output logic        ms_ovf
);

`ifdef UART_ARB_HEX_MS_EN
    localparam logic [2:0] LAST_IDX = 3'd7;
`else
    localparam logic [2:0] LAST_IDX = 3'd2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KB   = 2'd1,
        ST_MS   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [23:0] r_hold;       // mouse holding register
    logic        r_ms_pend;    // holding register contains an unsent report
    logic        r_ms_ovf;
    logic [23:0] r_shift;      // packet currently being transmitted
    logic [2:0]  r_cnt;        // byte index within the mouse packet
    logic        r_last_ms;    // 1: last grant went to the mouse
    logic        r_wr;
    logic        r_rd;
    logic [7:0]  r_data;

    logic        w_kb_req;
    logic        w_ms_req;
    logic        w_grant_kb;
    logic        w_grant_ms;
    logic        w_wr_nxt;
    logic        w_rd_nxt;
    logic [7:0]  w_data_nxt;
    logic [2:0]  w_cnt_nxt;
    logic [7:0]  w_ms_byte;

    // Uppercase ASCII hex character for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return {4'h3, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

    // While the pop strobe is out, the FIFO still shows the byte being
    // popped; masking avoids granting that same byte a second time.
    assign w_kb_req = ~kb_buf_empty & ~r_rd;
    assign w_ms_req = r_ms_pend;

    // Round-robin arbitration, only evaluated in IDLE.
    always_comb begin
        w_grant_kb = 1'b0;
        w_grant_ms = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_kb_req && w_ms_req) begin
                if (r_last_ms) begin
                    w_grant_kb = 1'b1;
                end else begin
                    w_grant_ms = 1'b1;
                end
            end else if (w_kb_req) begin
                w_grant_kb = 1'b1;
            end else if (w_ms_req) begin
                w_grant_ms = 1'b1;
            end else begin
                w_grant_kb = 1'b0;
                w_grant_ms = 1'b0;
            end
        end else begin
            w_grant_kb = 1'b0;
            w_grant_ms = 1'b0;
        end
    end

    // Selects the outgoing mouse byte for the current byte index.
    always_comb begin
        w_ms_byte = 8'h00;
`ifdef UART_ARB_HEX_MS_EN
        case (r_cnt)
            3'd0:    w_ms_byte = hex_char(r_shift[7:4]);
            3'd1:    w_ms_byte = hex_char(r_shift[3:0]);
            3'd2:    w_ms_byte = hex_char(r_shift[15:12]);
            3'd3:    w_ms_byte = hex_char(r_shift[11:8]);
            3'd4:    w_ms_byte = hex_char(r_shift[23:20]);
            3'd5:    w_ms_byte = hex_char(r_shift[19:16]);
            3'd6:    w_ms_byte = 8'h0D;
            3'd7:    w_ms_byte = 8'h0A;
            default: w_ms_byte = 8'h00;
        endcase
`else
        case (r_cnt)
            3'd0:    w_ms_byte = r_shift[7:0];
            3'd1:    w_ms_byte = r_shift[15:8];
            3'd2:    w_ms_byte = r_shift[23:16];
            default: w_ms_byte = 8'h00;
        endcase
`endif
    end

    // Next-state and next-output logic of the arbiter FSM.
    always_comb begin
        w_next_state = r_state;
        w_wr_nxt     = 1'b0;
        w_rd_nxt     = 1'b0;
        w_data_nxt   = 8'h00;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_kb) begin
                    w_next_state = ST_KB;
                end else if (w_grant_ms) begin
                    w_next_state = ST_MS;
                    w_cnt_nxt    = 3'd0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_KB: begin
                if (kb_buf_empty) begin
                    // Source vanished; never pop an empty FIFO.
                    w_next_state = ST_IDLE;
                end else if (!tx_full) begin
                    w_wr_nxt     = 1'b1;
                    w_rd_nxt     = 1'b1;
                    w_data_nxt   = kb_data;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_KB;
                end
            end
            ST_MS: begin
                if (!tx_full) begin
                    w_wr_nxt   = 1'b1;
                    w_data_nxt = w_ms_byte;
                    if (r_cnt == LAST_IDX) begin
                        w_cnt_nxt    = 3'd0;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_cnt_nxt    = r_cnt + 3'd1;
                        w_next_state = ST_MS;
                    end
                end else begin
                    w_next_state = ST_MS;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_nxt    = 3'd0;
            end
        endcase
    end

    // FSM state register and byte counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered UART write port and keyboard pop strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_data <= 8'h00;
        end else begin
            r_wr   <= w_wr_nxt;
            r_rd   <= w_rd_nxt;
            r_data <= w_data_nxt;
        end
    end

    // Mouse holding register, pending/overflow flags and transmit copy.
    // A grant frees the holding register in the same cycle, so a report
    // arriving then is captured rather than dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold    <= 24'h000000;
            r_shift   <= 24'h000000;
            r_ms_pend <= 1'b0;
            r_ms_ovf  <= 1'b0;
        end else begin
            if (w_grant_ms) begin
                r_shift <= r_hold;
            end else begin
                r_shift <= r_shift;
            end
            if (ms_valid && (!r_ms_pend || w_grant_ms)) begin
                r_hold    <= ms_pkt;
                r_ms_pend <= 1'b1;
            end else if (ms_valid) begin
                r_ms_ovf  <= 1'b1;
            end else if (w_grant_ms) begin
                r_ms_pend <= 1'b0;
            end else begin
                r_ms_pend <= r_ms_pend;
            end
        end
    end

    // Round-robin history: remembers which requester was granted last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_ms <= 1'b1;
        end else if (w_grant_kb) begin
            r_last_ms <= 1'b0;
        end else if (w_grant_ms) begin
            r_last_ms <= 1'b1;
        end else begin
            r_last_ms <= r_last_ms;
        end
    end

    assign wr_uart = r_wr;
    assign rd_kb   = r_rd;
    assign w_data  = r_data;
    assign ms_ovf  = r_ms_ovf;

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Directed testbench for uart_tx_arb. A small FWFT FIFO model feeds the
// keyboard side; a negedge monitor logs every UART write with its cycle
// number. Builds with or without UART_ARB_HEX_MS_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arb;

`ifdef UART_ARB_HEX_MS_EN
    localparam int PKT = 8;
    logic [7:0] exp030 [0:PKT-1] = '{8'h30, 8'h38, 8'h46, 8'h45, 8'h30, 8'h35, 8'h0D, 8'h0A};
`else
    localparam int PKT = 3;
    logic [7:0] exp030 [0:PKT-1] = '{8'h08, 8'hFE, 8'h05};
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        kb_buf_empty = 1'b1;
    logic [7:0]  kb_data = 8'h00;
    logic        rd_kb;
    logic        ms_valid = 1'b0;
    logic [23:0] ms_pkt = 24'h000000;
    logic        tx_full = 1'b0;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        ms_ovf;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_rd_viol = 0;
    int          n_full_viol = 0;
    logic        prev_full = 1'b0;
    logic        pop_s;

    logic [7:0]  kb_q [$];
    logic [7:0]  log_q [$];
    int          log_cyc [$];
    logic        log_rd [$];

    uart_tx_arb dut (
        .clk          (clk),
        .reset        (reset),
        .kb_buf_empty (kb_buf_empty),
        .kb_data      (kb_data),
        .rd_kb        (rd_kb),
        .ms_valid     (ms_valid),
        .ms_pkt       (ms_pkt),
        .tx_full      (tx_full),
        .wr_uart      (wr_uart),
        .w_data       (w_data),
        .ms_ovf       (ms_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] exp_byte(input logic [23:0] pkt, input int idx);
`ifdef UART_ARB_HEX_MS_EN
        logic [7:0] b;
        logic [3:0] nib;
        if (idx == 6) return 8'h0D;
        if (idx == 7) return 8'h0A;
        b   = pkt[8*(idx/2) +: 8];
        nib = (idx % 2 == 0) ? b[7:4] : b[3:0];
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        return 8'h41 + {4'h0, nib} - 8'h0A;
`else
        return pkt[8*idx +: 8];
`endif
    endfunction

    function void kb_refresh();
        kb_buf_empty = (kb_q.size() == 0);
        kb_data      = (kb_q.size() == 0) ? 8'h00 : kb_q[0];
    endfunction

    // FWFT FIFO model: a strobe seen during a cycle pops at its closing edge.
    always @(posedge clk) begin
        pop_s = rd_kb;
        #1;
        if (pop_s && kb_q.size() > 0) void'(kb_q.pop_front());
        kb_refresh();
    end

    // Output monitor and invariant watch.
    always @(negedge clk) begin
        if (!reset && wr_uart) begin
            log_q.push_back(w_data);
            log_cyc.push_back(cyc);
            log_rd.push_back(rd_kb);
        end
        if (!reset && rd_kb && kb_buf_empty) n_rd_viol++;
        if (!reset && wr_uart && prev_full) n_full_viol++;
        prev_full = tx_full;
    end

    task tick();
        @(posedge clk);
        #2;
    endtask

    task kb_push(input logic [7:0] b);
        kb_q.push_back(b);
        kb_refresh();
    endtask

    task clear_log();
        log_q.delete();
        log_cyc.delete();
        log_rd.delete();
    endtask

    task do_reset();
        reset    = 1'b1;
        ms_valid = 1'b0;
        ms_pkt   = 24'h000000;
        tx_full  = 1'b0;
        kb_q.delete();
        kb_refresh();
        repeat (3) tick();
        reset = 1'b0;
        clear_log();
    endtask

    task test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_checks++; if (wr_uart !== 1'b0) begin n_fail++; $display("FAIL reset_wr_uart: got %0b want 0", wr_uart); end
        n_checks++; if (rd_kb !== 1'b0) begin n_fail++; $display("FAIL reset_rd_kb: got %0b want 0", rd_kb); end
        n_checks++; if (w_data !== 8'h00) begin n_fail++; $display("FAIL reset_w_data: got %02h want 00", w_data); end
        n_checks++; if (ms_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ms_ovf: got %0b want 0", ms_ovf); end
        reset = 1'b0;
        clear_log();
        repeat (5) tick();
        n_checks++; if (log_q.size() != 0) begin n_fail++; $display("FAIL idle_no_write: got %0d writes want 0", log_q.size()); end
    endtask

    task test_kb_only();
        int  c0;
        bit  found;
        clear_log();
        tick();
        kb_push(8'h41);
        c0 = cyc;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_uart) begin found = 1'b1; break; end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL kb_wr_seen: got none want one write"); end
        n_checks++; if (cyc != c0 + 2) begin n_fail++; $display("FAIL kb_latency: got %0d cycles want 2", cyc - c0); end
        n_checks++; if (w_data !== 8'h41) begin n_fail++; $display("FAIL kb_data: got %02h want 41", w_data); end
        n_checks++; if (rd_kb !== 1'b1) begin n_fail++; $display("FAIL kb_rd_coincident: got %0b want 1", rd_kb); end
        repeat (6) tick();
        n_checks++; if (log_q.size() != 1) begin n_fail++; $display("FAIL kb_single_write: got %0d want 1", log_q.size()); end
        n_checks++; if (kb_buf_empty !== 1'b1) begin n_fail++; $display("FAIL kb_popped: got empty=%0b want 1", kb_buf_empty); end
        kb_push(8'h42);
        repeat (6) tick();
        n_checks++; if (log_q.size() != 2) begin n_fail++; $display("FAIL kb_back_idle: got %0d writes want 2", log_q.size()); end
        else begin
            n_checks++; if (log_q[1] !== 8'h42) begin n_fail++; $display("FAIL kb_second_data: got %02h want 42", log_q[1]); end
            n_checks++; if (log_rd[1] !== 1'b1) begin n_fail++; $display("FAIL kb_second_rd: got %0b want 1", log_rd[1]); end
        end
    endtask

    task test_mouse_only();
        int c0;
        bit consec;
        clear_log();
        tick();
        ms_pkt = 24'h05FE08;
        ms_valid = 1'b1;
        c0 = cyc;
        tick();
        ms_valid = 1'b0;
        repeat (15) tick();
        n_checks++; if (log_q.size() != PKT) begin n_fail++; $display("FAIL ms_count: got %0d want %0d", log_q.size(), PKT); end
        else begin
            consec = 1'b1;
            for (int i = 0; i < PKT; i++) begin
                n_checks++; if (log_q[i] !== exp030[i]) begin n_fail++; $display("FAIL ms_byte%0d: got %02h want %02h", i, log_q[i], exp030[i]); end
                if (i > 0 && log_cyc[i] != log_cyc[i-1] + 1) consec = 1'b0;
            end
            n_checks++; if (log_cyc[0] != c0 + 3) begin n_fail++; $display("FAIL ms_latency: got %0d want %0d", log_cyc[0] - c0, 3); end
            n_checks++; if (!consec) begin n_fail++; $display("FAIL ms_consecutive: got gaps want back-to-back bytes"); end
        end
    endtask

    task test_tie();
        do_reset();
        // Phase 1: first tie after reset goes to the keyboard.
        tick(); ms_pkt = 24'h332211; ms_valid = 1'b1;
        tick(); ms_valid = 1'b0; kb_push(8'h55);
        repeat (20) tick();
        n_checks++; if (log_q.size() != PKT + 1) begin n_fail++; $display("FAIL tie1_count: got %0d want %0d", log_q.size(), PKT + 1); end
        else begin
            n_checks++; if (log_q[0] !== 8'h55) begin n_fail++; $display("FAIL tie1_kb_first: got %02h want 55", log_q[0]); end
            for (int i = 0; i < PKT; i++) begin
                n_checks++; if (log_q[i+1] !== exp_byte(24'h332211, i)) begin n_fail++; $display("FAIL tie1_ms%0d: got %02h want %02h", i, log_q[i+1], exp_byte(24'h332211, i)); end
            end
        end
        // Phase 2: last grant was mouse, so the keyboard wins again.
        clear_log();
        tick(); ms_pkt = 24'h665544; ms_valid = 1'b1;
        tick(); ms_valid = 1'b0; kb_push(8'h66);
        repeat (20) tick();
        n_checks++; if (log_q.size() != PKT + 1) begin n_fail++; $display("FAIL tie2_count: got %0d want %0d", log_q.size(), PKT + 1); end
        else begin
            n_checks++; if (log_q[0] !== 8'h66) begin n_fail++; $display("FAIL tie2_kb_first: got %02h want 66", log_q[0]); end
        end
        // Phase 3: after a lone keyboard grant, a tie goes to the mouse.
        kb_push(8'h77);
        repeat (6) tick();
        clear_log();
        tick(); ms_pkt = 24'h998877; ms_valid = 1'b1;
        tick(); ms_valid = 1'b0; kb_push(8'h78);
        repeat (20) tick();
        n_checks++; if (log_q.size() != PKT + 1) begin n_fail++; $display("FAIL tie3_count: got %0d want %0d", log_q.size(), PKT + 1); end
        else begin
            n_checks++; if (log_q[0] !== exp_byte(24'h998877, 0)) begin n_fail++; $display("FAIL tie3_ms_first: got %02h want %02h", log_q[0], exp_byte(24'h998877, 0)); end
            n_checks++; if (log_q[PKT] !== 8'h78) begin n_fail++; $display("FAIL tie3_kb_last: got %02h want 78", log_q[PKT]); end
        end
    endtask

    task test_stall();
        int c0;
        clear_log();
        tick(); ms_pkt = 24'h0C0B0A; ms_valid = 1'b1; c0 = cyc;
        tick(); ms_valid = 1'b0;
        tick();
        tick();
        tick(); tx_full = 1'b1;
        repeat (5) tick();
        tx_full = 1'b0;
        repeat (15) tick();
        n_checks++; if (log_q.size() != PKT) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", log_q.size(), PKT); end
        else begin
            for (int i = 0; i < PKT; i++) begin
                n_checks++; if (log_q[i] !== exp_byte(24'h0C0B0A, i)) begin n_fail++; $display("FAIL stall_byte%0d: got %02h want %02h", i, log_q[i], exp_byte(24'h0C0B0A, i)); end
            end
            n_checks++; if (log_cyc[1] != c0 + 4) begin n_fail++; $display("FAIL stall_byte1_cycle: got %0d want %0d", log_cyc[1] - c0, 4); end
            n_checks++; if (log_cyc[2] != c0 + 10) begin n_fail++; $display("FAIL stall_byte2_cycle: got %0d want %0d", log_cyc[2] - c0, 10); end
        end
    endtask

    task test_overflow();
        do_reset();
        tick(); tx_full = 1'b1; kb_push(8'h20);
        tick();
        tick(); ms_pkt = 24'hA3A2A1; ms_valid = 1'b1;
        tick(); ms_pkt = 24'hB3B2B1; ms_valid = 1'b1;
        tick(); ms_valid = 1'b0;
        tick();
        n_checks++; if (ms_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b want 1", ms_ovf); end
        tx_full = 1'b0;
        repeat (20) tick();
        n_checks++; if (log_q.size() != PKT + 1) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", log_q.size(), PKT + 1); end
        else begin
            n_checks++; if (log_q[0] !== 8'h20) begin n_fail++; $display("FAIL ovf_kb: got %02h want 20", log_q[0]); end
            for (int i = 0; i < PKT; i++) begin
                n_checks++; if (log_q[i+1] !== exp_byte(24'hA3A2A1, i)) begin n_fail++; $display("FAIL ovf_held%0d: got %02h want %02h", i, log_q[i+1], exp_byte(24'hA3A2A1, i)); end
            end
        end
        n_checks++; if (ms_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", ms_ovf); end
        // A report arriving in the grant cycle must be kept.
        do_reset();
        n_checks++; if (ms_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %0b want 0", ms_ovf); end
        tick(); ms_pkt = 24'hC3C2C1; ms_valid = 1'b1;
        tick(); ms_pkt = 24'hD3D2D1; ms_valid = 1'b1;
        tick(); ms_valid = 1'b0;
        repeat (25) tick();
        n_checks++; if (log_q.size() != 2 * PKT) begin n_fail++; $display("FAIL grant_cycle_count: got %0d want %0d", log_q.size(), 2 * PKT); end
        else begin
            for (int i = 0; i < PKT; i++) begin
                n_checks++; if (log_q[i] !== exp_byte(24'hC3C2C1, i)) begin n_fail++; $display("FAIL grant_cycle_a%0d: got %02h want %02h", i, log_q[i], exp_byte(24'hC3C2C1, i)); end
                n_checks++; if (log_q[PKT+i] !== exp_byte(24'hD3D2D1, i)) begin n_fail++; $display("FAIL grant_cycle_b%0d: got %02h want %02h", i, log_q[PKT+i], exp_byte(24'hD3D2D1, i)); end
            end
        end
        n_checks++; if (ms_ovf !== 1'b0) begin n_fail++; $display("FAIL grant_cycle_no_ovf: got %0b want 0", ms_ovf); end
    endtask

    task test_reset_mid();
        bit found;
        do_reset();
        tick(); ms_pkt = 24'h030201; ms_valid = 1'b1;
        tick(); ms_pkt = 24'h0F0E0D; ms_valid = 1'b1;
        tick(); ms_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_uart) begin found = 1'b1; break; end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL midrst_byte0_seen: got none want one write"); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (wr_uart !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_uart: got %0b want 0", wr_uart); end
        n_checks++; if (w_data !== 8'h00) begin n_fail++; $display("FAIL midrst_w_data: got %02h want 00", w_data); end
        n_checks++; if (rd_kb !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_kb: got %0b want 0", rd_kb); end
        n_checks++; if (ms_ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_ms_ovf: got %0b want 0", ms_ovf); end
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        n_checks++; if (log_q.size() != 1) begin n_fail++; $display("FAIL midrst_aborted: got %0d writes want 1", log_q.size()); end
        else begin
            n_checks++; if (log_q[0] !== exp_byte(24'h030201, 0)) begin n_fail++; $display("FAIL midrst_byte0: got %02h want %02h", log_q[0], exp_byte(24'h030201, 0)); end
        end
    endtask

    task test_invariants();
        n_checks++; if (n_rd_viol != 0) begin n_fail++; $display("FAIL rd_while_empty: got %0d events want 0", n_rd_viol); end
        n_checks++; if (n_full_viol != 0) begin n_fail++; $display("FAIL wr_after_full: got %0d events want 0", n_full_viol); end
    endtask

    initial begin
        test_reset();
        test_kb_only();
        test_mouse_only();
        test_tie();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
